ramen_order_master: RTL
=======================

// Module: ramen_order_master
// PURPOSE
//  Customer-side initiator for the ramen-shop order protocol. Buffers host orders in a small FIFO and drives selling/in_valid/ramen_type/portion.
//  Collects per-order out_valid_order/success replies and the end-of-session out_valid_tot summary.
//  Cross-checks the shop's sold_num/total_gain against locally tracked successful orders.
// PARAMETERS
//  DEPTH      4   order FIFO entries (power of 2, >=2)
//  TIMEOUT    8   max cycles waiting for any shop reply before abort
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   async active-low reset
//  ord_valid       in   1   host order push request
//  ord_ready       out  1   FIFO not full (= !full, no bypass)
//  ord_type        in   2   0 TONKOTSU, 1 TONKOTSU_SOY, 2 MISO, 3 MISO_SOY
//  ord_portion     in   1   0 small, 1 large
//  ord_last        in   1   this order closes the session
//  selling         out  1   to shop: session open
//  in_valid        out  1   to shop: order beat valid
//  ramen_type      out  2   to shop: type (beat0), 0 otherwise
//  portion         out  1   to shop: portion (beat1), 0 otherwise
//  out_valid_order in   1   from shop: order reply strobe
//  success         in   1   from shop: order served
//  out_valid_tot   in   1   from shop: session summary strobe
//  sold_num        in   28  {tonkotsu,tonkotsu_soy,miso,miso_soy}, 7b each
//  total_gain      in   15  session revenue
//  res_valid       out  1   1-cycle per-order result strobe
//  res_success     out  1   shop success for that order
//  res_type        out  2   type of that order
//  sum_valid       out  1   1-cycle session summary strobe
//  sum_match       out  1   shop sold_num and total_gain equal local expectation
//  err_timeout     out  1   1-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, local counters 0, FSM S_IDLE. ord_ready is 1 after reset.
//  Shop-facing outputs (selling,in_valid,ramen_type,portion) are registered.
//  FIFO entry {last,portion,type}: push when ord_valid&&ord_ready; pop at BEAT1. Push+pop in one cycle allowed.
//  FSM: S_IDLE -> S_BEAT0 -> S_BEAT1 -> S_WAIT_ORD -> (S_BEAT0 | S_WAIT_TOT) -> S_IDLE.
//   S_IDLE: FIFO non-empty -> S_BEAT0. Next cycle drives selling=1,in_valid=1,ramen_type=head.type.
//    Selling and the first beat rise together. S_IDLE always lasts >=1 cycle.
//   S_BEAT0 -> S_BEAT1: drive in_valid=1,portion=head.portion,selling=1; pop head; latch type/last.
//   S_BEAT1 -> S_WAIT_ORD: in_valid=0. selling=0 if latched last, else selling stays 1.
//   S_WAIT_ORD: on out_valid_order -> res_valid=1 next cycle with res_success=success, res_type.
//    If success, increment local count[type] (7b, wraps mod 128).
//    If !last and FIFO non-empty -> S_BEAT0 (beat0 on cycle after reply).
//    If !last and FIFO empty -> wait in S_WAIT_NEXT (selling held 1) until non-empty.
//    If last -> S_WAIT_TOT.
//   S_WAIT_TOT: on out_valid_tot -> sum_valid=1 next cycle; sum_match=(sold_num==local counts) && (total_gain==exp_gain); clear counts; -> S_IDLE.
//    out_valid_order and out_valid_tot in same cycle (last order): take order result first, summary the next cycle.
//  exp_gain = 200*(n0+n2) + 250*(n1+n3), 15b, portion-independent.
//  Timeout: 4b counter, cleared on entering S_WAIT_ORD/S_WAIT_TOT. Reaching TIMEOUT with no strobe:
//   err_timeout pulse; selling=0,in_valid=0; clear counts; -> S_IDLE. FIFO contents kept.
//  Shop strobes outside wait states are ignored.
//  Reset mid-session: immediate return to reset values; FIFO flushed.
// TESTING
//  Push MISO/large/last -> selling+in_valid c0, portion=1 c1, selling=0 c2; shop success -> res_success=1,res_type=2; tot {0,0,1,0},200 -> sum_match=1.
//  3 orders T0 small, T1 large, T3 last; shop replies 1,0,1 -> 3 res_valid; sold_num={1,0,0,1}, gain 450 -> sum_match=1.
//  Same run with shop gain 400 -> sum_valid=1, sum_match=0.
//  DEPTH+1 pushes with no shop reply -> ord_ready=0 after 4; err_timeout 8 cycles after beat1; selling=0.
//  Non-last order, FIFO empty after reply -> selling held 1, in_valid 0, until next push; then beat0 the cycle after push.
//  rst_n low during S_WAIT_ORD -> all outputs 0 asynchronously, ord_ready=1, next session starts clean.

Source files
------------

// File: rtl/ramen_order_master.sv
// Customer-side initiator for the ramen-shop order protocol: buffers host orders,
// drives the two-beat order handshake, and cross-checks the shop's session summary.
module ramen_order_master #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ord_valid,
  output logic        ord_ready,
  input  logic [1:0]  ord_type,
  input  logic        ord_portion,
  input  logic        ord_last,
  output logic        selling,
  output logic        in_valid,
  output logic [1:0]  ramen_type,
  output logic        portion,
  input  logic        out_valid_order,
  input  logic        success,
  input  logic        out_valid_tot,
  input  logic [27:0] sold_num,
  input  logic [14:0] total_gain,
  output logic        res_valid,
  output logic        res_success,
  output logic [1:0]  res_type,
  output logic        sum_valid,
  output logic        sum_match,
  output logic        err_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_BEAT0, S_BEAT1, S_WAIT_ORD, S_WAIT_NEXT, S_WAIT_TOT
  } state_t;

  state_t state, state_d;

  logic [3:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [3:0]  head;

  assign full      = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
  assign empty     = (wr_ptr == rd_ptr);
  assign ord_ready = !full;
  assign push      = ord_valid && !full;
  assign head      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {ord_last, ord_portion, ord_type};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic [6:0]  cnt [4];
  logic [6:0]  cnt_d [4];
  logic [3:0]  tmo, tmo_d;
  logic [1:0]  cur_type, cur_type_d;
  logic        cur_last, cur_last_d;
  logic        tot_pend, tot_pend_d;
  logic [27:0] sold_q, sold_q_d;
  logic [14:0] gain_q, gain_q_d;
  logic        selling_d, in_valid_d, portion_d;
  logic [1:0]  ramen_type_d, res_type_d;
  logic        res_valid_d, res_success_d, sum_valid_d, sum_match_d, err_d;
  logic        start_beat, abort, clear_cnt;
  logic [14:0] exp_gain;
  logic [27:0] sold_cmp;
  logic [14:0] gain_cmp;

  assign exp_gain = 15'd200 * (15'(cnt[0]) + 15'(cnt[2]))
                  + 15'd250 * (15'(cnt[1]) + 15'(cnt[3]));
  // A summary that arrived together with the last reply is replayed from the capture.
  assign sold_cmp = tot_pend ? sold_q : sold_num;
  assign gain_cmp = tot_pend ? gain_q : total_gain;

  always_comb begin
    state_d       = state;
    selling_d     = selling;
    in_valid_d    = 1'b0;
    ramen_type_d  = '0;
    portion_d     = 1'b0;
    res_valid_d   = 1'b0;
    res_success_d = res_success;
    res_type_d    = res_type;
    sum_valid_d   = 1'b0;
    sum_match_d   = sum_match;
    err_d         = 1'b0;
    pop           = 1'b0;
    cnt_d         = cnt;
    tmo_d         = tmo;
    cur_type_d    = cur_type;
    cur_last_d    = cur_last;
    tot_pend_d    = tot_pend;
    sold_q_d      = sold_q;
    gain_q_d      = gain_q;
    start_beat    = 1'b0;
    abort         = 1'b0;
    clear_cnt     = 1'b0;

    case (state)
      S_IDLE: start_beat = !empty;
      S_BEAT0: begin
        state_d    = S_BEAT1;
        selling_d  = 1'b1;
        in_valid_d = 1'b1;
        portion_d  = head[2];
        pop        = 1'b1;
        cur_type_d = head[1:0];
        cur_last_d = head[3];
      end
      S_BEAT1: begin
        state_d   = S_WAIT_ORD;
        selling_d = !cur_last;
        tmo_d     = '0;
      end
      S_WAIT_ORD: begin
        if (out_valid_order) begin
          res_valid_d   = 1'b1;
          res_success_d = success;
          res_type_d    = cur_type;
          if (success) cnt_d[cur_type] = cnt[cur_type] + 7'd1;
          if (cur_last) begin
            state_d = S_WAIT_TOT;
            tmo_d   = '0;
            if (out_valid_tot) begin
              tot_pend_d = 1'b1;
              sold_q_d   = sold_num;
              gain_q_d   = total_gain;
            end
          end else if (!empty) begin
            start_beat = 1'b1;
          end else begin
            state_d = S_WAIT_NEXT;
          end
        end else if (tmo == 4'(TIMEOUT - 1)) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo + 4'd1;
        end
      end
      S_WAIT_NEXT: start_beat = !empty;
      S_WAIT_TOT: begin
        if (tot_pend || out_valid_tot) begin
          sum_valid_d = 1'b1;
          sum_match_d = (sold_cmp == {cnt[0], cnt[1], cnt[2], cnt[3]}) && (gain_cmp == exp_gain);
          clear_cnt   = 1'b1;
          tot_pend_d  = 1'b0;
          selling_d   = 1'b0;
          state_d     = S_IDLE;
        end else if (tmo == 4'(TIMEOUT - 1)) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_beat) begin
      state_d      = S_BEAT0;
      selling_d    = 1'b1;
      in_valid_d   = 1'b1;
      ramen_type_d = head[1:0];
    end
    if (abort) begin
      err_d      = 1'b1;
      selling_d  = 1'b0;
      in_valid_d = 1'b0;
      tot_pend_d = 1'b0;
      clear_cnt  = 1'b1;
      state_d    = S_IDLE;
    end
    if (clear_cnt) begin
      for (int unsigned i = 0; i < 4; i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      selling     <= 1'b0;
      in_valid    <= 1'b0;
      ramen_type  <= '0;
      portion     <= 1'b0;
      res_valid   <= 1'b0;
      res_success <= 1'b0;
      res_type    <= '0;
      sum_valid   <= 1'b0;
      sum_match   <= 1'b0;
      err_timeout <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
      tmo         <= '0;
      cur_type    <= '0;
      cur_last    <= 1'b0;
      tot_pend    <= 1'b0;
      sold_q      <= '0;
      gain_q      <= '0;
    end else begin
      state       <= state_d;
      selling     <= selling_d;
      in_valid    <= in_valid_d;
      ramen_type  <= ramen_type_d;
      portion     <= portion_d;
      res_valid   <= res_valid_d;
      res_success <= res_success_d;
      res_type    <= res_type_d;
      sum_valid   <= sum_valid_d;
      sum_match   <= sum_match_d;
      err_timeout <= err_d;
      cnt         <= cnt_d;
      tmo         <= tmo_d;
      cur_type    <= cur_type_d;
      cur_last    <= cur_last_d;
      tot_pend    <= tot_pend_d;
      sold_q      <= sold_q_d;
      gain_q      <= gain_q_d;
    end
  end

endmodule
